// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem requests, prefetch FIFO, output register to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INST_W     = 16,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              do_branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              do_jump,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              stall,
  input  logic              is_halt,
  fetch_unit_if.master      imem,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
`ifdef FETCH_PERF_EN
  output logic              halted,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_flushed
`else
  output logic              halted
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int QW = CW + 1;
  localparam int DW = PW + 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] q_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc   [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outst;
  logic [DW-1:0]     drop_cnt;

  logic              redirect;
  logic              hlt;
  logic              redir;
  logic              halt_go;
  logic              normal;
  logic              pop;
  logic              accept;
  logic              push;
  logic              dropping;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] rsp_pc;
  logic [QW-1:0]     credit;

  assign redirect = do_branch | do_jump;
  assign target   = do_branch ? branch_addr : jump_address;
  assign hlt      = (state == HALTED);
  assign redir    = !hlt && redirect;
  assign halt_go  = (state == RUN) && !is_halt
                 && !stall && !redirect;
  assign normal   = !hlt && !redir && !halt_go;
  assign pop      = normal && !stall && (count != '0);

  // Occupancy after this cycle's pop, so a draining
  // FIFO can keep one request per cycle in flight.
  assign credit = {1'b0, count} - QW'(pop)
                + {1'b0, outst};

  assign imem.req  = normal && (state == RUN)
                  && (credit < QW'(FIFO_DEPTH));
  assign imem.addr = pc;

  assign accept   = imem.req && imem.ready;
  assign dropping = imem.rvalid && (drop_cnt != '0);
  assign push     = normal && imem.rvalid
                 && (drop_cnt == '0);

  // Live requests are consecutive from the last
  // redirect, so the oldest one sits outst behind pc.
  assign rsp_pc = pc - ADDR_W'(outst);
  assign halted = hlt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      outst     <= '0;
      drop_cnt  <= '0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE) state <= RUN;
      unique case (1'b1)
        hlt: begin
          out_inst  <= '0;
          out_pc    <= '0;
          out_valid <= 1'b0;
        end
        redir: begin
          pc        <= target;
          rd_ptr    <= '0;
          wr_ptr    <= '0;
          count     <= '0;
          outst     <= '0;
          drop_cnt  <= drop_cnt + DW'(outst)
                     - DW'(imem.rvalid);
          out_inst  <= '0;
          out_pc    <= '0;
          out_valid <= 1'b0;
        end
        halt_go: begin
          state     <= HALTED;
          rd_ptr    <= '0;
          wr_ptr    <= '0;
          count     <= '0;
          outst     <= '0;
          drop_cnt  <= '0;
          out_inst  <= '0;
          out_pc    <= '0;
          out_valid <= 1'b0;
        end
        default: begin
          if (accept) pc <= pc + ADDR_W'(1);
          outst <= outst + CW'(accept) - CW'(push);
          if (dropping) drop_cnt <= drop_cnt - DW'(1);
          if (push) begin
            q_inst[wr_ptr] <= imem.rdata;
            q_pc[wr_ptr]   <= rsp_pc;
            wr_ptr         <= wr_ptr + PW'(1);
          end
          count <= count + CW'(push) - CW'(pop);
          if (!stall) begin
            if (pop) begin
              out_inst  <= q_inst[rd_ptr];
              out_pc    <= q_pc[rd_ptr];
              out_valid <= 1'b1;
              rd_ptr    <= rd_ptr + PW'(1);
            end else begin
              out_inst  <= '0;
              out_pc    <= '0;
              out_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [QW-1:0] flush_n;
  logic [16:0]   flush_sum;

  assign flush_n = hlt ? QW'(imem.rvalid)
                 : (redir || halt_go)
                   ? {1'b0, count} + QW'(imem.rvalid)
                   : QW'(dropping);
  assign flush_sum = {1'b0, perf_flushed} + 17'(flush_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      perf_flushed <= flush_sum[16] ? 16'hFFFF
                                    : flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked
// against an in-order instruction-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        do_branch = 1'b0;
  logic        do_jump = 1'b0;
  logic        stall = 1'b0;
  logic        is_halt = 1'b1;
  logic [15:0] branch_addr = '0;
  logic [15:0] jump_address = '0;

  int lat   [2];
  int rmode [2];
  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        out_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif
    logic [15:0]  qa [$];
    int unsigned  qd [$];
    int unsigned  cyc;

    fetch_unit_if #(.ADDR_W(16), .INST_W(16)) bus ();

    fetch_unit #(
      .ADDR_W(16), .INST_W(16), .FIFO_DEPTH(2),
      .RESET_PC(g == 0 ? 16'h0000 : 16'hFFFE)
    ) dut (
      .clk(clk), .rst(rst),
      .do_branch(do_branch), .branch_addr(branch_addr),
      .do_jump(do_jump), .jump_address(jump_address),
      .stall(stall), .is_halt(is_halt),
      .imem(bus),
      .out_inst(out_inst), .out_pc(out_pc),
      .out_valid(out_valid),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed),
`endif
      .halted(halted)
    );

    // Memory: data(a) = a + 16'h1000, in order, fixed latency.
    initial begin
      cyc = 0;
      bus.ready = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata = '0;
      forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
          qa.delete();
          qd.delete();
          bus.ready = 1'b0;
          bus.rvalid = 1'b0;
        end else begin
          case (rmode[g])
            0:       bus.ready = 1'b1;
            1:       bus.ready = 1'($urandom_range(0, 1));
            default: bus.ready = cyc[0];
          endcase
          if (qa.size() > 0 && qd[0] <= cyc) begin
            bus.rvalid = 1'b1;
            bus.rdata = qa[0] + 16'h1000;
            void'(qa.pop_front());
            void'(qd.pop_front());
          end else begin
            bus.rvalid = 1'b0;
          end
          #1;
          if (bus.req && bus.ready) begin
            qa.push_back(bus.addr);
            qd.push_back(cyc + 32'(lat[g]));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    do_branch = 1'b0;
    do_jump = 1'b0;
    stall = 1'b0;
    is_halt = 1'b1;
    branch_addr = '0;
    jump_address = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat[0] = 1; lat[1] = 1;
    rmode[0] = 0; rmode[1] = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({g_dut[0].out_valid, g_dut[0].out_inst,
         g_dut[0].out_pc, g_dut[0].halted,
         g_dut[0].bus.req} !== 35'd0)
      $display("FAIL reset0: v=%b inst=%h pc=%h halted=%b req=%b, want all 0",
               g_dut[0].out_valid, g_dut[0].out_inst,
               g_dut[0].out_pc, g_dut[0].halted, g_dut[0].bus.req);
    else n_pass++;
    n_checks++;
    if (g_dut[0].bus.addr !== 16'h0000)
      $display("FAIL reset_addr0: got %h want 0000", g_dut[0].bus.addr);
    else n_pass++;
    n_checks++;
    if (g_dut[1].bus.addr !== 16'hFFFE || g_dut[1].out_valid !== 1'b0)
      $display("FAIL reset_addr1: addr=%h v=%b want FFFE 0",
               g_dut[1].bus.addr, g_dut[1].out_valid);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_straight();
    logic        ev;
    logic [15:0] ep, ei;
    lat[0] = 1; rmode[0] = 0;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ev = (k >= 4);
      ep = ev ? 16'(k - 4) : 16'h0;
      ei = ev ? ep + 16'h1000 : 16'h0;
      n_checks++;
      if ({g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst}
          !== {ev, ep, ei})
        $display("FAIL straight k=%0d: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                 k, g_dut[0].out_valid, g_dut[0].out_pc,
                 g_dut[0].out_inst, ev, ep, ei);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    lat[0] = 1; rmode[0] = 0;
    do_reset();
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = g_dut[0].out_valid && g_dut[0].out_pc == 16'h2;
    end
    n_checks++;
    if (!found) begin
      $display("FAIL stall_wait: pc 0002 never seen, want seen");
      return;
    end
    n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst}
          !== {1'b1, 16'h0002, 16'h1002})
        $display("FAIL stall_hold %0d: got v=%b pc=%h inst=%h want 1 0002 1002",
                 i, g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst);
      else n_pass++;
    end
    stall = 1'b0;
    for (int i = 3; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst}
          !== {1'b1, 16'(i), 16'(i) + 16'h1000})
        $display("FAIL stall_resume: got v=%b pc=%h want 1 %h",
                 g_dut[0].out_valid, g_dut[0].out_pc, 16'(i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect(input bit br, input logic [15:0] want);
    bit found = 0;
    lat[0] = 3; rmode[0] = 0;
    do_reset();
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = g_dut[0].out_valid;
    end
    do_jump = 1'b1;
    jump_address = 16'h0040;
    do_branch = br;
    branch_addr = 16'h0080;
    @(negedge clk);
    do_jump = 1'b0;
    do_branch = 1'b0;
    n_checks++;
    if ({g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst} !== 33'd0)
      $display("FAIL redir_nop: got v=%b pc=%h inst=%h want 0 0000 0000",
               g_dut[0].out_valid, g_dut[0].out_pc, g_dut[0].out_inst);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk);
        found = g_dut[0].out_valid;
      end
      n_checks++;
      if (!found || g_dut[0].out_pc !== want + 16'(k)
          || g_dut[0].out_inst !== want + 16'(k) + 16'h1000)
        $display("FAIL redir_target br=%0d k=%0d: got seen=%0d pc=%h inst=%h want pc=%h",
                 br, k, found, g_dut[0].out_pc, g_dut[0].out_inst,
                 want + 16'(k));
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    bit found = 0;
    lat[0] = 1; rmode[0] = 0;
    do_reset();
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = g_dut[0].out_valid && g_dut[0].out_pc == 16'h5;
    end
    is_halt = 1'b0;
    @(negedge clk);
    is_halt = 1'b1;
    n_checks++;
    if (!found || g_dut[0].halted !== 1'b1 || g_dut[0].out_valid !== 1'b0)
      $display("FAIL halt_enter: seen=%0d halted=%b v=%b want 1 1 0",
               found, g_dut[0].halted, g_dut[0].out_valid);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      do_jump = (i == 3);
      jump_address = 16'h0100;
      @(negedge clk);
      n_checks++;
      if ({g_dut[0].bus.req, g_dut[0].out_valid, g_dut[0].halted} !== 3'b001)
        $display("FAIL halt_hold %0d: got req=%b v=%b halted=%b want 0 0 1",
                 i, g_dut[0].bus.req, g_dut[0].out_valid, g_dut[0].halted);
      else n_pass++;
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (g_dut[0].halted !== 1'b0)
      $display("FAIL halt_clear: halted=%b want 0", g_dut[0].halted);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int got = 0;
    logic [15:0] want;
    lat[0] = 3; lat[1] = 3;
    rmode[0] = 2; rmode[1] = 2;
    do_reset();
    for (int i = 0; i < 200 && got < 3; i++) begin
      @(negedge clk);
      if (g_dut[1].out_valid) begin
        want = 16'hFFFE + 16'(got);
        n_checks++;
        if (g_dut[1].out_pc !== want || g_dut[1].out_inst !== want + 16'h1000)
          $display("FAIL wrap %0d: got pc=%h inst=%h want pc=%h inst=%h",
                   got, g_dut[1].out_pc, g_dut[1].out_inst,
                   want, want + 16'h1000);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 3)
      $display("FAIL wrap_count: got %0d outputs want 3", got);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc = 16'h0;
    logic [15:0] tgt = 16'h0;
    logic        pv = 1'b0;
    logic [15:0] ppc = '0, pinst = '0;
    bit          was_stall = 0, was_redir = 0;
    logic        v;
    logic [15:0] pc, inst;
    int          nvalid = 0;
    lat[0] = int'($urandom_range(1, 3));
    rmode[0] = 1; rmode[1] = 1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      v = g_dut[0].out_valid;
      pc = g_dut[0].out_pc;
      inst = g_dut[0].out_inst;
      n_checks++;
      if (was_redir) begin
        if ({v, pc, inst} !== 33'd0)
          $display("FAIL rand_redir c=%0d: got v=%b pc=%h inst=%h want nop",
                   c, v, pc, inst);
        else n_pass++;
        exp_pc = tgt;
      end else if (was_stall) begin
        if ({v, pc, inst} !== {pv, ppc, pinst})
          $display("FAIL rand_stall c=%0d: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                   c, v, pc, inst, pv, ppc, pinst);
        else n_pass++;
      end else if (v) begin
        if (pc !== exp_pc || inst !== exp_pc + 16'h1000)
          $display("FAIL rand_stream c=%0d: got pc=%h inst=%h want pc=%h inst=%h",
                   c, pc, inst, exp_pc, exp_pc + 16'h1000);
        else n_pass++;
        exp_pc = exp_pc + 16'h1;
        nvalid++;
      end else begin
        if (pc !== 16'h0 || inst !== 16'h0)
          $display("FAIL rand_nop c=%0d: got pc=%h inst=%h want 0000 0000",
                   c, pc, inst);
        else n_pass++;
      end
      pv = v; ppc = pc; pinst = inst;
      stall = ($urandom_range(0, 3) == 0);
      do_branch = ($urandom_range(0, 31) == 0);
      do_jump = ($urandom_range(0, 31) == 0);
      branch_addr = 16'($urandom);
      jump_address = 16'($urandom);
      was_stall = stall;
      was_redir = do_branch || do_jump;
      tgt = do_branch ? branch_addr : jump_address;
    end
    stall = 1'b0;
    do_branch = 1'b0;
    do_jump = 1'b0;
    n_checks++;
    if (nvalid < 20)
      $display("FAIL rand_progress: got %0d valid outputs want >= 20", nvalid);
    else n_pass++;
  endtask

  initial begin
    lat[0] = 1; lat[1] = 1;
    rmode[0] = 0; rmode[1] = 0;
    test_reset();
    test_straight();
    test_stall();
    test_redirect(1'b0, 16'h0040);
    test_redirect(1'b1, 16'h0080);
    test_halt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

endmodule
